pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. It sits beside the ID stage and the operand-forwarding mux, and covers the hazards forwarding cannot resolve: load-use, multiply/divide busy, memory-stage bus wait and exception flush. It drives per-stage stall and bubble controls. It also counts stall cycles and aborts hung memory transactions with a timeout.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared access-op encodings and hazard FSM state constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ACCESS_OP_NONE = 2'd0;
    localparam logic [1:0] ACCESS_OP_D2R  = 2'd1;  // ALU result to register
    localparam logic [1:0] ACCESS_OP_M2R  = 2'd2;  // load
    localparam logic [1:0] ACCESS_OP_R2M  = 2'd3;  // store

    typedef logic [1:0] state_t;

    localparam state_t c_ST_RUN       = 2'd0;
    localparam state_t c_ST_MEM_WAIT  = 2'd1;
    localparam state_t c_ST_EXC_PEND  = 2'd2;
    localparam state_t c_ST_EXC_FLUSH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use and multiply/divide busy hazard compare.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_addr,
    input  logic       id_rs_used,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rt_used,
    input  logic [4:0] ex_dest_addr,
    input  logic [1:0] ex_access_op,
    input  logic       id_uses_hilo,
    input  logic       md_busy,
    output logic       hazard
);

    logic w_dest_match;
    logic w_load_use;
    logic w_md_hazard;

    // $0 is hardwired to zero, so a load targeting it never produces a value.
    assign w_dest_match = (id_rs_used && (id_rs_addr == ex_dest_addr)) ||
                          (id_rt_used && (id_rt_addr == ex_dest_addr));
    assign w_load_use   = (ex_access_op == ACCESS_OP_M2R) &&
                          (ex_dest_addr != 5'd0) && w_dest_match;
    assign w_md_hazard  = id_uses_hilo && md_busy;
    assign hazard       = w_load_use || w_md_hazard;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/bubble/flush sequencer with bus timeout and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs_addr,
    input  logic                 id_rs_used,
    input  logic [4:0]           id_rt_addr,
    input  logic                 id_rt_used,
    input  logic [4:0]           ex_dest_addr,
    input  logic [1:0]           ex_access_op,
    input  logic                 id_uses_hilo,
    input  logic                 md_busy,
    input  logic                 mm_busy,
    input  logic                 exc_req,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mm,
    output logic                 bubble_ex,
    output logic                 bubble_wb,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mm,
    output logic                 exc_ack,
    output logic                 bus_timeout,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_count;
    logic                  w_hazard;
    logic                  w_timeout_hit;

    hazard_detect u_hazard_detect (
        .id_rs_addr   (id_rs_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_addr   (id_rt_addr),
        .id_rt_used   (id_rt_used),
        .ex_dest_addr (ex_dest_addr),
        .ex_access_op (ex_access_op),
        .id_uses_hilo (id_uses_hilo),
        .md_busy      (md_busy),
        .hazard       (w_hazard)
    );

    // The bus is declared hung on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign w_timeout_hit = ((r_state == c_ST_MEM_WAIT) || (r_state == c_ST_EXC_PEND)) &&
                           mm_busy && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_ST_RUN) || (r_state == c_ST_EXC_FLUSH)) begin
                r_wait_cnt <= '0;
            end else if (mm_busy && (r_wait_cnt != c_WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (stall_if) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mm    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_wb   = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        flush_mm    = 1'b0;
        exc_ack     = 1'b0;
        bus_timeout = 1'b0;
        case (r_state)
            c_ST_EXC_FLUSH: begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
                flush_mm = 1'b1;
                exc_ack  = 1'b1;
                w_next   = c_ST_RUN;
            end
            c_ST_EXC_PEND: begin
                {stall_if, stall_id, stall_ex, stall_mm, bubble_wb} = 5'b11111;
                if (w_timeout_hit) begin
                    bus_timeout = 1'b1;
                    w_next      = c_ST_EXC_FLUSH;
                end else if (!mm_busy) begin
                    w_next = c_ST_EXC_FLUSH;
                end
            end
            default: begin
                // RUN, and MEM_WAIT once the bus has released, behave identically.
                if (mm_busy) begin
                    {stall_if, stall_id, stall_ex, stall_mm, bubble_wb} = 5'b11111;
                    if (w_timeout_hit) begin
                        bus_timeout = 1'b1;
                        w_next      = c_ST_EXC_FLUSH;
                    end else if (exc_req) begin
                        w_next = c_ST_EXC_PEND;
                    end else begin
                        w_next = c_ST_MEM_WAIT;
                    end
                end else if (exc_req) begin
                    {stall_if, stall_id, stall_ex, stall_mm} = 4'b1111;
                    w_next = c_ST_EXC_FLUSH;
                end else begin
                    w_next = c_ST_RUN;
                    if (w_hazard) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
            end
        endcase
        if (rst) begin
            {stall_if, stall_id, stall_ex, stall_mm, bubble_ex, bubble_wb} = 6'b0;
            {flush_id, flush_ex, flush_mm, exc_ack, bus_timeout}           = 5'b0;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Output vector order: stall_if stall_id stall_ex stall_mm bubble_ex bubble_wb
    //                      flush_id flush_ex flush_mm exc_ack bus_timeout
    localparam logic [10:0] c_O_NONE  = 11'b000_0000_0000;
    localparam logic [10:0] c_O_LU    = 11'b110_0100_0000;
    localparam logic [10:0] c_O_MEM   = 11'b111_1010_0000;
    localparam logic [10:0] c_O_EXC   = 11'b111_1000_0000;
    localparam logic [10:0] c_O_FLUSH = 11'b000_0001_1110;
    localparam logic [10:0] c_O_TO    = 11'b111_1010_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, ex_dest_addr = '0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic [1:0]  ex_access_op = ACCESS_OP_NONE;
    logic        id_uses_hilo = 1'b0, md_busy = 1'b0, mm_busy = 1'b0, exc_req = 1'b0;
    logic        stall_if, stall_id, stall_ex, stall_mm, bubble_ex, bubble_wb;
    logic        flush_id, flush_ex, flush_mm, exc_ack, bus_timeout;
    logic [31:0] stall_count;
    logic [10:0] outs;
    logic [31:0] exp_cnt = '0;
    int          total = 0;
    int          bad   = 0;

    assign outs = {stall_if, stall_id, stall_ex, stall_mm, bubble_ex, bubble_wb,
                   flush_id, flush_ex, flush_mm, exc_ack, bus_timeout};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
        .ex_dest_addr(ex_dest_addr), .ex_access_op(ex_access_op),
        .id_uses_hilo(id_uses_hilo), .md_busy(md_busy),
        .mm_busy(mm_busy), .exc_req(exc_req),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mm(flush_mm),
        .exc_ack(exc_ack), .bus_timeout(bus_timeout), .stall_count(stall_count)
    );

    task automatic clear_inputs();
        id_rs_addr = '0; id_rs_used = 1'b0; id_rt_addr = '0; id_rt_used = 1'b0;
        ex_dest_addr = '0; ex_access_op = ACCESS_OP_NONE;
        id_uses_hilo = 1'b0; md_busy = 1'b0; mm_busy = 1'b0; exc_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        mm_busy = 1'b1; exc_req = 1'b1; md_busy = 1'b1; id_uses_hilo = 1'b1;
        #1;
        total++;
        if (outs !== c_O_NONE) begin bad++; $display("FAIL reset_outs: got=%b exp=%b", outs, c_O_NONE); end
        total++;
        if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_cnt: got=%0d exp=0", stall_count); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        total++;
        if (outs !== c_O_NONE) begin bad++; $display("FAIL reset_idle: got=%b exp=%b", outs, c_O_NONE); end
    endtask

    task automatic test_load_use();
        // Vectors: op, dest, rs, rs_used, rt, rt_used, expected outputs.
        logic [1:0]  op  [6] = '{ACCESS_OP_M2R, ACCESS_OP_NONE, ACCESS_OP_M2R,
                                 ACCESS_OP_M2R, ACCESS_OP_M2R, ACCESS_OP_D2R};
        logic [4:0]  dst [6] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5};
        logic [4:0]  rs  [6] = '{5'd5, 5'd5, 5'd5, 5'd3, 5'd0, 5'd5};
        logic        rsu [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0]  rt  [6] = '{5'd0, 5'd0, 5'd9, 5'd5, 5'd0, 5'd0};
        logic        rtu [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [10:0] exp [6] = '{c_O_LU, c_O_NONE, c_O_NONE, c_O_LU, c_O_NONE, c_O_NONE};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ex_access_op = op[i]; ex_dest_addr = dst[i];
            id_rs_addr = rs[i]; id_rs_used = rsu[i];
            id_rt_addr = rt[i]; id_rt_used = rtu[i];
            #1;
            total++;
            if (outs !== exp[i]) begin bad++; $display("FAIL load_use[%0d]: got=%b exp=%b", i, outs, exp[i]); end
            if (exp[i][10]) exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (stall_count !== exp_cnt) begin bad++; $display("FAIL load_use_cnt: got=%0d exp=%0d", stall_count, exp_cnt); end
    endtask

    task automatic test_md_hazard();
        logic        hl  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        mdb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [10:0] exp [4] = '{c_O_LU, c_O_LU, c_O_NONE, c_O_NONE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_uses_hilo = hl[i]; md_busy = mdb[i];
            #1;
            total++;
            if (outs !== exp[i]) begin bad++; $display("FAIL md_hazard[%0d]: got=%b exp=%b", i, outs, exp[i]); end
            if (exp[i][10]) exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        // Busy for 4 cycles with a load-use also present; busy must win, then the
        // hazard is seen again on the release cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ex_access_op = ACCESS_OP_M2R; ex_dest_addr = 5'd7;
            id_rt_addr = 5'd7; id_rt_used = 1'b1;
            mm_busy = (i < 4);
            #1;
            total++;
            if (outs !== ((i < 4) ? c_O_MEM : c_O_LU)) begin
                bad++; $display("FAIL mem_wait[%0d]: got=%b exp=%b", i, outs, (i < 4) ? c_O_MEM : c_O_LU);
            end
            exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (outs !== c_O_NONE) begin bad++; $display("FAIL mem_wait_after: got=%b exp=%b", outs, c_O_NONE); end
        total++;
        if (stall_count !== exp_cnt) begin bad++; $display("FAIL mem_wait_cnt: got=%0d exp=%0d", stall_count, exp_cnt); end
    endtask

    task automatic test_exc_idle();
        logic [10:0] exp [3] = '{c_O_EXC, c_O_FLUSH, c_O_NONE};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exc_req = (i < 2);
            #1;
            total++;
            if (outs !== exp[i]) begin bad++; $display("FAIL exc_idle[%0d]: got=%b exp=%b", i, outs, exp[i]); end
            if (exp[i][10]) exp_cnt++;
        end
    endtask

    task automatic test_exc_pend();
        logic        mb  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        er  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [10:0] exp [7] = '{c_O_MEM, c_O_MEM, c_O_MEM, c_O_MEM, c_O_MEM, c_O_FLUSH, c_O_NONE};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mm_busy = mb[i]; exc_req = er[i];
            #1;
            total++;
            if (outs !== exp[i]) begin bad++; $display("FAIL exc_pend[%0d]: got=%b exp=%b", i, outs, exp[i]); end
            if (exp[i][10]) exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (stall_count !== exp_cnt) begin bad++; $display("FAIL exc_pend_cnt: got=%0d exp=%0d", stall_count, exp_cnt); end
    endtask

    task automatic test_timeout();
        // RUN cycle, eight wait cycles (timeout on the eighth), flush with the bus
        // still stuck, then back in RUN once the bus is quiet.
        logic [10:0] e;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            mm_busy = (i < 10);
            #1;
            e = (i < 8) ? c_O_MEM : (i == 8) ? c_O_TO : (i == 9) ? c_O_FLUSH : c_O_NONE;
            total++;
            if (outs !== e) begin bad++; $display("FAIL timeout[%0d]: got=%b exp=%b", i, outs, e); end
            if (e[10]) exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (stall_count !== exp_cnt) begin bad++; $display("FAIL timeout_cnt: got=%0d exp=%0d", stall_count, exp_cnt); end
    endtask

    task automatic test_reset_in_pend();
        @(negedge clk); mm_busy = 1'b1;
        @(negedge clk); exc_req = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (outs !== c_O_MEM) begin bad++; $display("FAIL pend_before_rst: got=%b exp=%b", outs, c_O_MEM); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (outs !== c_O_NONE) begin bad++; $display("FAIL pend_in_rst: got=%b exp=%b", outs, c_O_NONE); end
        exp_cnt = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b0;
            clear_inputs();
            #1;
            total++;
            if (outs !== c_O_NONE) begin bad++; $display("FAIL pend_after_rst[%0d]: got=%b exp=%b", i, outs, c_O_NONE); end
            total++;
            if (stall_count !== exp_cnt) begin bad++; $display("FAIL pend_rst_cnt[%0d]: got=%0d exp=%0d", i, stall_count, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        // Load-use, then MD hazard, then a fresh exception, with no idle cycle between.
        logic [10:0] exp [4] = '{c_O_LU, c_O_LU, c_O_EXC, c_O_FLUSH};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            case (i)
                0: begin ex_access_op = ACCESS_OP_M2R; ex_dest_addr = 5'd31; id_rs_addr = 5'd31; id_rs_used = 1'b1; end
                1: begin id_uses_hilo = 1'b1; md_busy = 1'b1; end
                default: exc_req = 1'b1;
            endcase
            #1;
            total++;
            if (outs !== exp[i]) begin bad++; $display("FAIL back_to_back[%0d]: got=%b exp=%b", i, outs, exp[i]); end
            if (exp[i][10]) exp_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (stall_count !== exp_cnt) begin bad++; $display("FAIL back_to_back_cnt: got=%0d exp=%0d", stall_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_md_hazard();
        test_mem_wait();
        test_exc_idle();
        test_exc_pend();
        test_timeout();
        test_reset_in_pend();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
